cu_iter: RTL and testbench
==========================

// Module: cu_iter
// PURPOSE
//  Iterative compare unit: evaluates EQ/NE/LT/GE/LTU/GEU on two WIDTH-bit operands, CHUNK bits
//  per cycle, MSB chunk first, with valid/ready handshakes on input and output. It is the
//  area-reduced, multi-cycle replacement for the single-cycle branch comparator in the execute stage.
//  It also serves SLT/SLTU via out_lt.
// PARAMETERS
//  WIDTH      32  operand width; must be a multiple of CHUNK
//  CHUNK       8  bits compared per cycle; 1..WIDTH; NCHUNK = WIDTH/CHUNK
//  EARLY_EXIT  1  1: finish at first differing chunk; 0: always scan all NCHUNK chunks
// PORTS
//  clk                  in   1      clock; all state on rising edge
//  rst                  in   1      asynchronous reset, active-high
//  flush                in   1      synchronous abort of any in-flight compare
//  in_valid             in   1      request valid
//  in_ready             out  1      unit can accept a request
//  ra, rb               in   WIDTH  operands
//  lt                   in   1      1: select less-than result; 0: select equality result
//  invert               in   1      invert the selected result (NE/GE/GEU)
//  unsigned_comparison  in   1      1: unsigned; 0: two's-complement signed
//  out_valid            out  1      result valid
//  out_ready            in   1      consumer takes result
//  out                  out  1      invert ^ (lt ? lt_result : eq_result)
//  out_lt, out_eq       out  1      raw lt_result / eq_result, unaffected by lt/invert
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=out=out_lt=out_eq=0; operand/mode regs and counter cleared.
//  States:
//   IDLE  in_ready = !flush. On in_valid && in_ready: latch ra_/rb_, lt, invert and chunk counter
//         (NCHUNK-1), then go to SCAN. ra_ is ra with MSB replaced by (!unsigned_comparison ^ ra[MSB]);
//         rb_ is built the same way from rb.
//   SCAN  each cycle compare top CHUNK bits a_c, b_c of shift regs.
//         If a_c != b_c and no difference recorded yet: record lt_r = (a_c < b_c), eq_r = 0.
//         End-of-scan: (EARLY_EXIT && first difference this cycle) or counter == 0.
//         At end, if no difference was ever recorded: eq_r = 1, lt_r = 0. Go to DONE.
//         Otherwise shift both regs left by CHUNK, decrement counter, stay in SCAN.
//         With EARLY_EXIT=0 later chunks never overwrite the first recorded difference.
//   DONE  out_valid = 1; out/out_lt/out_eq are driven from registers and held stable while
//         !out_ready. On out_ready: go to IDLE with out_valid = 0 next cycle.
//  Latency: request accepted at edge 0 -> chunk i (0 = MS chunk) compared in cycle i+1.
//   out_valid rises at cycle k+2, where k = index of the first differing chunk (EARLY_EXIT=1),
//   or k = NCHUNK-1 (equal operands, or EARLY_EXIT=0).
//  Throughput: one request per (latency + 1 handshake) cycles. No overlap; in_ready is 0
//   outside IDLE.
//  CHUNK == WIDTH: a single SCAN cycle, so out_valid at cycle 2.
//  flush: highest priority below rst. From SCAN or DONE -> IDLE at next edge, out_valid = 0,
//   result discarded. In IDLE it blocks acceptance.
//  rst mid-operation: immediate return to reset values; the pending request is lost and
//   never reported.
//  in_valid while busy: ignored (no acceptance). The requester must hold the request until
//   in_ready.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1 ra=rb=0x00000005, lt=0, inv=0 -> out=1, out_eq=1; out_valid at cycle 5 (all 4 chunks scanned).
//  2 ra=0xFFFFFFFF, rb=0x1, lt=1, signed -> out=1 at cycle 2.
//    Same with unsigned_comparison=1 -> out=0, out_lt=0.
//  3 ra=0x100, rb=0x101, lt=1, unsigned, inv=1 (BGEU) -> out=0 at cycle 5, for both
//    EARLY_EXIT=1 and EARLY_EXIT=0. Also ra=0x80000000 vs rb=0: EARLY_EXIT=0 -> cycle 5.
//  4 out_ready held low 3 cycles in DONE -> out stable, in_ready=0. Then out_ready=1 ->
//    in_ready=1 next cycle; back-to-back request accepted.
//  5 flush asserted in 2nd SCAN cycle -> out_valid never rises; in_ready=1 next cycle;
//    a new request completes correctly.
//  6 rst pulsed mid-SCAN (asynchronously, between edges) -> outputs reset immediately;
//    next request unaffected. Also CHUNK=32: every compare gives out_valid at cycle 2.

Source files
------------

// File: rtl/cu_iter.sv
// Iterative compare unit: evaluates EQ/NE/LT/GE/LTU/GEU on two WIDTH-bit operands,
// CHUNK bits per cycle starting at the most significant chunk, behind valid/ready
// handshakes. Signed compares are turned into unsigned ones by flipping the operand
// MSBs at acceptance, so the chunk datapath only ever does unsigned compares.
module cu_iter #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic             lt,
    input  logic             invert,
    input  logic             unsigned_comparison,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic             out_lt,
    output logic             out_eq
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lt_sel_q, lt_sel_d;
    logic               inv_q, inv_d;
    logic               lt_r_q, lt_r_d;
    logic               eq_r_q, eq_r_d;
    logic               diff_q, diff_d;

    logic [CHUNK-1:0]   a_c;
    logic [CHUNK-1:0]   b_c;
    logic [WIDTH-1:0]   sign_flip;
    logic               new_diff;
    logic               scan_end;

    // Current chunk under comparison, first-difference detection and end-of-scan decision
    always_comb begin
        a_c       = a_q[WIDTH-1 -: CHUNK];
        b_c       = b_q[WIDTH-1 -: CHUNK];
        sign_flip = {~unsigned_comparison, {(WIDTH-1){1'b0}}};
        new_diff  = (a_c != b_c) && !diff_q;
        scan_end  = (EARLY_EXIT && new_diff) || (cnt_q == '0);
    end

    // Next-state and handshake logic; flush aborts any in-flight compare
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        lt_sel_d  = lt_sel_q;
        inv_d     = inv_q;
        lt_r_d    = lt_r_q;
        eq_r_d    = eq_r_q;
        diff_d    = diff_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = !flush;
                if (in_valid && !flush) begin
                    a_d      = ra ^ sign_flip;
                    b_d      = rb ^ sign_flip;
                    cnt_d    = CNT_W'(NCHUNK - 1);
                    lt_sel_d = lt;
                    inv_d    = invert;
                    diff_d   = 1'b0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (new_diff) begin
                        lt_r_d = (a_c < b_c);
                        eq_r_d = 1'b0;
                        diff_d = 1'b1;
                    end
                    if (scan_end) begin
                        if (!diff_q && !new_diff) begin
                            lt_r_d = 1'b0;
                            eq_r_d = 1'b1;
                        end
                        state_d = DONE;
                    end else begin
                        a_d   = a_q << CHUNK;
                        b_d   = b_q << CHUNK;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand shift registers, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            lt_sel_q <= 1'b0;
            inv_q    <= 1'b0;
            lt_r_q   <= 1'b0;
            eq_r_q   <= 1'b0;
            diff_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            lt_sel_q <= lt_sel_d;
            inv_q    <= inv_d;
            lt_r_q   <= lt_r_d;
            eq_r_q   <= eq_r_d;
            diff_q   <= diff_d;
        end
    end

    assign out    = inv_q ^ (lt_sel_q ? lt_r_q : eq_r_q);
    assign out_lt = lt_r_q;
    assign out_eq = eq_r_q;

endmodule

// File: tb/tb_cu_iter.sv
// Bench for cu_iter: three instances (early exit, full scan, single-chunk) share the
// operand bus; a vector table covers the compare modes, and hand-written sequences cover
// backpressure, flush and asynchronous reset.
module tb_cu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] ra = '0;
    logic [31:0] rb = '0;
    logic        lt_i = 1'b0;
    logic        inv_i = 1'b0;
    logic        uns_i = 1'b0;
    logic [2:0]  in_valid = '0;

    logic in_ready_0, out_valid_0, out_0, out_lt_0, out_eq_0;
    logic in_ready_1, out_valid_1, out_1, out_lt_1, out_eq_1;
    logic in_ready_2, out_valid_2, out_2, out_lt_2, out_eq_2;

    logic [2:0] rdy_v, val_v, out_v, lt_v, eq_v;

    int tests = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic        lt;
        logic        inv;
        logic        uns;
        int          sel;
        logic        exp_out;
        logic        exp_lt;
        logic        exp_eq;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[15];

    cu_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[0]), .in_ready(in_ready_0),
        .ra(ra), .rb(rb), .lt(lt_i), .invert(inv_i), .unsigned_comparison(uns_i),
        .out_valid(out_valid_0), .out_ready(out_ready), .out(out_0), .out_lt(out_lt_0),
        .out_eq(out_eq_0)
    );

    cu_iter #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[1]), .in_ready(in_ready_1),
        .ra(ra), .rb(rb), .lt(lt_i), .invert(inv_i), .unsigned_comparison(uns_i),
        .out_valid(out_valid_1), .out_ready(out_ready), .out(out_1), .out_lt(out_lt_1),
        .out_eq(out_eq_1)
    );

    cu_iter #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1'b1)) dut_wide (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[2]), .in_ready(in_ready_2),
        .ra(ra), .rb(rb), .lt(lt_i), .invert(inv_i), .unsigned_comparison(uns_i),
        .out_valid(out_valid_2), .out_ready(out_ready), .out(out_2), .out_lt(out_lt_2),
        .out_eq(out_eq_2)
    );

    assign rdy_v = {in_ready_2, in_ready_1, in_ready_0};
    assign val_v = {out_valid_2, out_valid_1, out_valid_0};
    assign out_v = {out_2, out_1, out_0};
    assign lt_v  = {out_lt_2, out_lt_1, out_lt_0};
    assign eq_v  = {out_eq_2, out_eq_1, out_eq_0};

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a request to one instance and hold it across the accepting edge
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic l, input logic iv, input logic u);
        ra = a;
        rb = b;
        lt_i = l;
        inv_i = iv;
        uns_i = u;
        in_valid = '0;
        in_valid[sel] = 1'b1;
        checkOutput("in_ready_at_request", {31'b0, rdy_v[sel]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    // Count cycles after the accepting edge until out_valid, bounded
    task automatic waitResult(input int sel, output int cyc);
        cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (val_v[sel]) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL result_timeout: got no out_valid, expected out_valid within 20 cycles");
        end
    endtask

    initial begin
        int cyc;
        logic seen;

        vecs[0]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 5};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{32'h0000_0100, 32'h0000_0101, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 5};
        vecs[4]  = '{32'h0000_0100, 32'h0000_0101, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 5};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 5};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 5};
        vecs[8]  = '{32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 5};
        vecs[9]  = '{32'h0001_0000, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 2};
        vecs[10] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 2};
        vecs[11] = '{32'h0000_0003, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 2};
        vecs[12] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 2};
        vecs[13] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 5};
        vecs[14] = '{32'h00FF_0000, 32'h00FE_0000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3};

        // Reset
        #2 rst = 1'b1;
        #11 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", {31'b0, in_ready_0}, 32'd1);
        checkOutput("reset_out_valid", {31'b0, out_valid_0}, 32'd0);
        checkOutput("reset_out", {31'b0, out_0}, 32'd0);
        checkOutput("reset_out_lt", {31'b0, out_lt_0}, 32'd0);
        checkOutput("reset_out_eq", {31'b0, out_eq_0}, 32'd0);
        checkOutput("reset_in_ready_wide", {31'b0, in_ready_2}, 32'd1);

        // Table-driven compares
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].sel, vecs[i].ra, vecs[i].rb, vecs[i].lt, vecs[i].inv,
                          vecs[i].uns);
            waitResult(vecs[i].sel, cyc);
            checkOutput($sformatf("v%0d_latency", i), cyc, vecs[i].exp_cyc);
            checkOutput($sformatf("v%0d_out", i), {31'b0, out_v[vecs[i].sel]},
                        {31'b0, vecs[i].exp_out});
            checkOutput($sformatf("v%0d_out_lt", i), {31'b0, lt_v[vecs[i].sel]},
                        {31'b0, vecs[i].exp_lt});
            checkOutput($sformatf("v%0d_out_eq", i), {31'b0, eq_v[vecs[i].sel]},
                        {31'b0, vecs[i].exp_eq});
        end

        // Backpressure: result held while out_ready low, busy requests ignored
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        waitResult(0, cyc);
        checkOutput("hold_latency", cyc, 32'd2);
        ra = 32'h0;
        rb = 32'h0;
        lt_i = 1'b0;
        in_valid[0] = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d_out_valid", h), {31'b0, out_valid_0}, 32'd1);
            checkOutput($sformatf("hold%0d_out", h), {31'b0, out_0}, 32'd1);
            checkOutput($sformatf("hold%0d_out_eq", h), {31'b0, out_eq_0}, 32'd0);
            checkOutput($sformatf("hold%0d_in_ready", h), {31'b0, in_ready_0}, 32'd0);
        end
        in_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'b0, in_ready_0}, 32'd1);
        checkOutput("release_out_valid", {31'b0, out_valid_0}, 32'd0);
        applyStimulus(0, 32'h0000_0100, 32'h0000_0101, 1'b1, 1'b1, 1'b1);
        waitResult(0, cyc);
        checkOutput("b2b_latency", cyc, 32'd5);
        checkOutput("b2b_out", {31'b0, out_0}, 32'd0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1;
        ra = 32'h1;
        rb = 32'h2;
        in_valid[0] = 1'b1;
        #1;
        checkOutput("flush_idle_in_ready", {31'b0, in_ready_0}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid_0) seen = 1'b1;
        end
        checkOutput("flush_idle_no_accept", {31'b0, seen}, 32'd0);

        // Flush during the second SCAN cycle discards the compare
        applyStimulus(0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_scan_in_ready", {31'b0, in_ready_0}, 32'd1);
        seen = out_valid_0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid_0) seen = 1'b1;
        end
        checkOutput("flush_scan_no_valid", {31'b0, seen}, 32'd0);
        applyStimulus(0, 32'h0000_0077, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
        waitResult(0, cyc);
        checkOutput("post_flush_latency", cyc, 32'd5);
        checkOutput("post_flush_out", {31'b0, out_0}, 32'd1);
        checkOutput("post_flush_out_eq", {31'b0, out_eq_0}, 32'd1);

        // Asynchronous reset between edges in mid-SCAN
        @(negedge clk);
        applyStimulus(0, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_in_ready", {31'b0, in_ready_0}, 32'd1);
        checkOutput("async_rst_out_eq", {31'b0, out_eq_0}, 32'd0);
        checkOutput("async_rst_out", {31'b0, out_0}, 32'd0);
        checkOutput("async_rst_out_valid", {31'b0, out_valid_0}, 32'd0);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid_0) seen = 1'b1;
        end
        checkOutput("async_rst_lost", {31'b0, seen}, 32'd0);
        applyStimulus(0, 32'h0000_0003, 32'h0000_0009, 1'b1, 1'b0, 1'b0);
        waitResult(0, cyc);
        checkOutput("post_rst_latency", cyc, 32'd5);
        checkOutput("post_rst_out", {31'b0, out_0}, 32'd1);
        checkOutput("post_rst_out_lt", {31'b0, out_lt_0}, 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
